// File: rtl/tdt_dmi_apb_arbiter_pkg.sv
// Shared types and helpers for the DMI APB arbiter.
// Holds the state encoding and the sizing rule for the timeout counter.
package tdt_dmi_apb_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    // Counter only has to reach TIMEOUT-1; keep at least one bit when disabled.
    function automatic int tcnt_width(input int timeout);
        if (timeout < 2) return 1;
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/tdt_dmi_apb_arbiter_rr.sv
// Two-way round-robin picker: a lone request wins outright,
// a tie goes to the requester that was not granted last time.
module tdt_dmi_arb_rr (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_vld,
    output logic       gnt_id
);

    assign gnt_vld = |req;
    assign gnt_id  = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/tdt_dmi_apb_arbiter.sv
// Shares the DMI APB master port between the DTM (s0) and system APB (s1) requesters.
// state | meaning: IDLE arbitrate+latch | SETUP psel only | ACCESS wait pready/timeout | RESP pulse pready
module tdt_dmi_apb_arbiter
    import tdt_dmi_apb_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              sys_apb_clk,
    input  logic              sys_apb_rst,
    input  logic              sysapb_en,
    input  logic              s0_psel,
    input  logic              s0_penable,
    input  logic              s0_pwrite,
    input  logic [ADDR_W-1:0] s0_paddr,
    input  logic [DATA_W-1:0] s0_pwdata,
    output logic [DATA_W-1:0] s0_prdata,
    output logic              s0_pready,
    output logic              s0_pslverr,
    input  logic              s1_psel,
    input  logic              s1_penable,
    input  logic              s1_pwrite,
    input  logic [ADDR_W-1:0] s1_paddr,
    input  logic [DATA_W-1:0] s1_pwdata,
    output logic [DATA_W-1:0] s1_prdata,
    output logic              s1_pready,
    output logic              s1_pslverr,
    output logic              m_psel,
    output logic              m_penable,
    output logic              m_pwrite,
    output logic [ADDR_W-1:0] m_paddr,
    output logic [DATA_W-1:0] m_pwdata,
    input  logic [DATA_W-1:0] m_prdata,
    input  logic              m_pready,
    input  logic              m_pslverr
);

    localparam int TCNT_W      = tcnt_width(TIMEOUT);
    localparam int TCNT_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TCNT_LAST_I);

    arb_state_t        state;
    logic              last_grant;
    logic              gnt_q;
    logic [TCNT_W-1:0] tcnt;

    logic [1:0]        req;
    logic              gnt_vld;
    logic              gnt_id;
    logic              timeout_hit;
    logic              access_done;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    // penable from the requesters carries no information the FSM needs.
    logic unused_penable;
    assign unused_penable = s0_penable ^ s1_penable;

    assign req = {s1_psel & sysapb_en, s0_psel};

    tdt_dmi_arb_rr u_rr (
        .req        (req),
        .last_grant (last_grant),
        .gnt_vld    (gnt_vld),
        .gnt_id     (gnt_id)
    );

    // A real pready in the last allowed cycle wins over the abort.
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (tcnt == TCNT_LAST);
        access_done = m_pready | timeout_hit;
        resp_data   = m_pready ? m_prdata : '0;
        resp_err    = m_pready ? m_pslverr : 1'b1;
    end

    always_ff @(posedge sys_apb_clk or posedge sys_apb_rst) begin
        if (sys_apb_rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            gnt_q      <= 1'b0;
            tcnt       <= '0;
            m_psel     <= 1'b0;
            m_penable  <= 1'b0;
            m_pwrite   <= 1'b0;
            m_paddr    <= '0;
            m_pwdata   <= '0;
            s0_pready  <= 1'b0;
            s0_prdata  <= '0;
            s0_pslverr <= 1'b0;
            s1_pready  <= 1'b0;
            s1_prdata  <= '0;
            s1_pslverr <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        gnt_q     <= gnt_id;
                        m_pwrite  <= gnt_id ? s1_pwrite : s0_pwrite;
                        m_paddr   <= gnt_id ? s1_paddr  : s0_paddr;
                        m_pwdata  <= gnt_id ? s1_pwdata : s0_pwdata;
                        m_psel    <= 1'b1;
                        m_penable <= 1'b0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    m_penable <= 1'b1;
                    state     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (access_done) begin
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        if (gnt_q) begin
                            s1_pready  <= 1'b1;
                            s1_prdata  <= resp_data;
                            s1_pslverr <= resp_err;
                        end else begin
                            s0_pready  <= 1'b1;
                            s0_prdata  <= resp_data;
                            s0_pslverr <= resp_err;
                        end
                        state <= ST_RESP;
                    end else if (TIMEOUT != 0) begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                ST_RESP: begin
                    s0_pready  <= 1'b0;
                    s0_prdata  <= '0;
                    s0_pslverr <= 1'b0;
                    s1_pready  <= 1'b0;
                    s1_prdata  <= '0;
                    s1_pslverr <= 1'b0;
                    last_grant <= gnt_q;
                    tcnt       <= '0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdt_dmi_apb_arbiter.sv
// Randomized bench for the DMI APB arbiter against a transaction-level model
// (grant rule, latency = 3 + waits capped by the timeout, response/abort values).
module tb_tdt_dmi_apb_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          sysapb_en;
    logic          s0_psel, s0_penable, s0_pwrite;
    logic [AW-1:0] s0_paddr;
    logic [DW-1:0] s0_pwdata, s0_prdata;
    logic          s0_pready, s0_pslverr;
    logic          s1_psel, s1_penable, s1_pwrite;
    logic [AW-1:0] s1_paddr;
    logic [DW-1:0] s1_pwdata, s1_prdata;
    logic          s1_pready, s1_pslverr;
    logic          m_psel, m_penable, m_pwrite;
    logic [AW-1:0] m_paddr;
    logic [DW-1:0] m_pwdata, m_prdata;
    logic          m_pready, m_pslverr;

    int n_checks = 0;
    int n_pass   = 0;
    bit model_last = 1'b1;

    always #5 clk = ~clk;

    tdt_dmi_apb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .sys_apb_clk (clk),
        .sys_apb_rst (rst),
        .sysapb_en   (sysapb_en),
        .s0_psel     (s0_psel),
        .s0_penable  (s0_penable),
        .s0_pwrite   (s0_pwrite),
        .s0_paddr    (s0_paddr),
        .s0_pwdata   (s0_pwdata),
        .s0_prdata   (s0_prdata),
        .s0_pready   (s0_pready),
        .s0_pslverr  (s0_pslverr),
        .s1_psel     (s1_psel),
        .s1_penable  (s1_penable),
        .s1_pwrite   (s1_pwrite),
        .s1_paddr    (s1_paddr),
        .s1_pwdata   (s1_pwdata),
        .s1_prdata   (s1_prdata),
        .s1_pready   (s1_pready),
        .s1_pslverr  (s1_pslverr),
        .m_psel      (m_psel),
        .m_penable   (m_penable),
        .m_pwrite    (m_pwrite),
        .m_paddr     (m_paddr),
        .m_pwdata    (m_pwdata),
        .m_prdata    (m_prdata),
        .m_pready    (m_pready),
        .m_pslverr   (m_pslverr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "/m"}, {m_psel, m_penable, m_pwrite, m_paddr, m_pwdata}, 64'd0);
        chk({tag, "/s0"}, {s0_pready, s0_pslverr, s0_prdata}, 64'd0);
        chk({tag, "/s1"}, {s1_pready, s1_pslverr, s1_prdata}, 64'd0);
    endtask

    // Called with the DUT in IDLE; returns with the DUT back in IDLE.
    task automatic run_txn(input string name, input bit r0, input bit r1, input bit en,
                           input int waits, input bit werr, input logic [DW-1:0] rd);
        bit            g, timed_out, quiet_bad;
        int            lat;
        logic [44:0]   exp_cmd;
        logic [DW-1:0] exp_rd;
        bit            exp_err;
        logic          gp;
        logic [DW-1:0] gd;
        logic          ge;

        quiet_bad  = 1'b0;
        s0_psel    = r0;  s0_penable = 1'b0;
        s0_pwrite  = 1'($urandom); s0_paddr = AW'($urandom); s0_pwdata = $urandom;
        s1_psel    = r1;  s1_penable = 1'b0;
        s1_pwrite  = 1'($urandom); s1_paddr = AW'($urandom); s1_pwdata = $urandom;
        sysapb_en  = en;
        m_pready   = 1'b0;

        if (!(r0 || (r1 && en))) begin
            repeat (4) begin
                tick();
                if (m_psel || s0_pready || s1_pready) quiet_bad = 1'b1;
            end
            chk({name, "/nogrant"}, 64'(quiet_bad), 64'd0);
            return;
        end

        g         = (r0 && r1 && en) ? !model_last : !r0;
        timed_out = (waits >= TO);
        lat       = 3 + (timed_out ? TO - 1 : waits);
        exp_cmd   = g ? {s1_pwrite, s1_paddr, s1_pwdata} : {s0_pwrite, s0_paddr, s0_pwdata};
        exp_rd    = timed_out ? '0 : rd;
        exp_err   = timed_out ? 1'b1 : werr;

        for (int c = 1; c <= lat + 1; c++) begin
            tick();
            if (c >= 2 && c < lat) begin
                m_pready  = (c - 2 == waits);
                m_prdata  = (c - 2 == waits) ? rd : $urandom;
                m_pslverr = (c - 2 == waits) ? werr : 1'($urandom);
            end else begin
                m_pready  = 1'b0;
                m_prdata  = $urandom;
                m_pslverr = 1'($urandom);
            end
            if (c < lat) begin
                chk({name, "/m_ctl"}, {m_psel, m_penable}, {1'b1, 1'(c >= 2)});
                chk({name, "/m_cmd"}, {m_pwrite, m_paddr, m_pwdata}, exp_cmd);
            end else begin
                chk({name, "/m_idle"}, {m_psel, m_penable}, 64'd0);
            end
            gp = g ? s1_pready  : s0_pready;
            gd = g ? s1_prdata  : s0_prdata;
            ge = g ? s1_pslverr : s0_pslverr;
            chk({name, "/pready"}, 64'(gp), 64'(c == lat));
            if (c == lat) chk({name, "/resp"}, {ge, gd}, {exp_err, exp_rd});
            if (g ? (s0_pready || s0_pslverr || s0_prdata != 0)
                  : (s1_pready || s1_pslverr || s1_prdata != 0)) quiet_bad = 1'b1;
        end
        model_last = g;
        chk({name, "/other_quiet"}, 64'(quiet_bad), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        sysapb_en = 1'b0;
        s0_psel = 1'b0; s0_penable = 1'b0; s0_pwrite = 1'b0; s0_paddr = '0; s0_pwdata = '0;
        s1_psel = 1'b0; s1_penable = 1'b0; s1_pwrite = 1'b0; s1_paddr = '0; s1_pwdata = '0;
        m_prdata = '0; m_pready = 1'b0; m_pslverr = 1'b0;
        repeat (2) tick();
        chk_all_zero("reset");
        #3 rst = 1'b0;
        tick();

        // tie after reset: s0, s1, s0, s1
        for (int i = 0; i < 4; i++) run_txn("alt", 1, 1, 1, 0, 0, $urandom);
        run_txn("s0_read", 1, 0, 0, 0, 0, 32'hDEADBEEF);
        run_txn("s1_blocked", 0, 1, 0, 0, 0, $urandom);
        run_txn("s1_write", 0, 1, 1, 2, 0, $urandom);
        run_txn("timeout", 1, 0, 1, 20, 0, $urandom);
        run_txn("last_ok", 1, 0, 1, TO - 1, 0, $urandom);
        run_txn("slverr", 0, 1, 1, 3, 1, $urandom);

        // reset during ACCESS
        s0_psel = 1'b1; s1_psel = 1'b1; sysapb_en = 1'b1; m_pready = 1'b0;
        tick();
        tick();
        chk("pre_rst/m_ctl", {m_psel, m_penable}, 64'd3);
        #2 rst = 1'b1;
        #1 chk_all_zero("mid_rst");
        rst = 1'b0;
        model_last = 1'b1;
        run_txn("post_rst", 1, 1, 1, 1, 0, $urandom);

        for (int i = 0; i < 30; i++)
            run_txn("rand", 1'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 10)), 1'($urandom), $urandom);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
